mips_multicycle_ctrl: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for each instruction. It drives every datapath mux and enable, and produces the 2-bit alu_op that feeds the existing ALU control decoder. Memory accesses stall on a ready handshake, and an illegal opcode is trapped.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mips_multicycle_ctrl.sv | 149 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, state and alu_op encodings for the multi-cycle MIPS control
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_IMM_EXEC  = 4'd11,
    ST_IMM_WB    = 4'd12,
    ST_ILLEGAL   = 4'd13
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multi-cycle MIPS datapath
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= opcode;
      if (state_d == ST_ILLEGAL) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC only load on the cycle the fetch actually completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW:       state_d = ST_MEM_ADDR;
          OP_RTYPE:           state_d = ST_R_EXEC;
          OP_BEQ:             state_d = ST_BRANCH;
          OP_J:               state_d = ST_JUMP;
          OP_ADDI, OP_ANDI:   state_d = ST_IMM_EXEC;
          default:            state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = ST_FETCH;
      end
      ST_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_q == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
        state_d   = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_ILLEGAL;
    endcase
  end

  // FETCH is reached from every completing state; RST and FETCH itself never retire
  assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_RST);

  assign illegal_op = illegal_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed vector bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [15:0] ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] c;
    logic [31:0] ret;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, psrc);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [15:0] c, input logic [31:0] ret, input logic ill);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.c = c; v.ret = ret; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [15:0] c,
                         input logic [31:0] ret, input logic ill);
    chk({tag, " state"}, {28'd0, state}, {28'd0, st});
    chk({tag, " ctrl"}, {16'd0, ctrl}, {16'd0, c});
    chk({tag, " retired"}, retired, ret);
    chk({tag, " illegal"}, {31'd0, illegal_op}, {31'd0, ill});
  endtask

  logic [15:0] c_f1, c_f0, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_rex, c_rwb;
  logic [15:0] c_br, c_j, c_iadd, c_iand, c_iwb, c_zero;

  initial begin
    c_zero = 16'd0;
    c_f1   = mk(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00);
    c_f0   = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    c_dec  = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    c_madr = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    c_mrd  = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    c_mwb  = mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
    c_mwr  = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    c_rex  = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    c_rwb  = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    c_br   = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
    c_j    = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
    c_iadd = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    c_iand = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b11, 2'b00);
    c_iwb  = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);

    // R-type
    add(6'b000000, 1, 1,  c_f1,   0, 0);
    add(6'b000000, 1, 2,  c_dec,  0, 0);
    add(6'b000000, 1, 7,  c_rex,  0, 0);
    add(6'b000000, 1, 8,  c_rwb,  0, 0);
    // lw, two wait cycles in MEM_READ
    add(6'b100011, 1, 1,  c_f1,   1, 0);
    add(6'b100011, 1, 2,  c_dec,  1, 0);
    add(6'b100011, 1, 3,  c_madr, 1, 0);
    add(6'b100011, 0, 4,  c_mrd,  1, 0);
    add(6'b100011, 0, 4,  c_mrd,  1, 0);
    add(6'b100011, 1, 4,  c_mrd,  1, 0);
    add(6'b100011, 1, 5,  c_mwb,  1, 0);
    // sw with one fetch wait cycle
    add(6'b101011, 0, 1,  c_f0,   2, 0);
    add(6'b101011, 1, 1,  c_f1,   2, 0);
    add(6'b101011, 1, 2,  c_dec,  2, 0);
    add(6'b101011, 1, 3,  c_madr, 2, 0);
    add(6'b101011, 1, 6,  c_mwr,  2, 0);
    // beq then j
    add(6'b000100, 1, 1,  c_f1,   3, 0);
    add(6'b000100, 1, 2,  c_dec,  3, 0);
    add(6'b000100, 1, 9,  c_br,   3, 0);
    add(6'b000010, 1, 1,  c_f1,   4, 0);
    add(6'b000010, 1, 2,  c_dec,  4, 0);
    add(6'b000010, 1, 10, c_j,    4, 0);
    // andi then addi, opcode swapped after DECODE
    add(6'b001100, 1, 1,  c_f1,   5, 0);
    add(6'b001100, 1, 2,  c_dec,  5, 0);
    add(6'b001000, 1, 11, c_iand, 5, 0);
    add(6'b001000, 1, 12, c_iwb,  5, 0);
    add(6'b001000, 1, 1,  c_f1,   6, 0);
    add(6'b001000, 1, 2,  c_dec,  6, 0);
    add(6'b001100, 1, 11, c_iadd, 6, 0);
    add(6'b001100, 1, 12, c_iwb,  6, 0);
    // illegal opcode
    add(6'b111111, 1, 1,  c_f1,   7, 0);
    add(6'b111111, 1, 2,  c_dec,  7, 0);
    add(6'b000000, 1, 13, c_zero, 7, 1);

    rst_n = 1'b0;
    opcode = 6'd0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 4'd0, c_zero, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1 chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].c, vecs[i].ret, vecs[i].ill);
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 6'($urandom);
      mem_ready = 1'($urandom);
      #1 chk_all($sformatf("illegal_hold%0d", i), 4'd13, c_zero, 7, 1);
    end

    rst_n = 1'b0;
    #1 chk_all("illegal_clear", 4'd0, c_zero, 0, 0);
    #1 rst_n = 1'b1;
    opcode = 6'b100011;
    mem_ready = 1'b1;
    @(negedge clk);
    #1 chk_all("post_reset_fetch", 4'd1, c_f1, 0, 0);

    // asynchronous reset in the middle of FETCH
    #1 rst_n = 1'b0;
    #1 chk_all("mid_fetch_reset", 4'd0, c_zero, 0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 chk_all("refetch", 4'd1, c_f1, 0, 0);

    // pending MEM_READ dropped by reset
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1 chk_all("pending_read", 4'd4, c_mrd, 0, 0);
    rst_n = 1'b0;
    #1 chk_all("read_dropped", 4'd0, c_zero, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk_all("after_drop", 4'd1, c_f0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
